simple_cpu: RTL and testbench

Minimal multicycle 8-bit load/store CPU core with a four-entry register file, an internal 32-entry data memory and a two-field opcode/function decoder. Instructions arrive on an external instruction bus held stable by the driver, so there is no program counter or instruction fetch from memory. The full register file is exported for observation. It is the top of the CPU hierarchy and contains the register file, ALU, data memory and control FSM.

---
 rtl/simple_cpu.sv | 93 +++++++++
 tb/tb_simple_cpu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/simple_cpu.sv
// rtl/simple_cpu.sv - multicycle 8-bit load/store core: register file, ALU, data memory, control FSM
module simple_cpu #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTR_WIDTH-1:0]       instruction,
  output logic [0:3][DATA_WIDTH-1:0]   out
);

  localparam int MEM_WORDS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE} state_t;

  state_t                       state;
  logic [INSTR_WIDTH-1:0]       ir;
  logic [0:3][DATA_WIDTH-1:0]   regs;
  logic [DATA_WIDTH-1:0]        mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0]        opa;
  logic [DATA_WIDTH-1:0]        opb;
  logic [ADDR_BITS-1:0]         addr;

  logic [1:0] op, x1, x2, x3;
  logic [7:0] imm;
  logic [3:0] funct;

  assign op    = ir[19:18];
  assign x1    = ir[17:16];
  assign x2    = ir[15:14];
  assign x3    = ir[13:12];
  assign imm   = ir[11:4];
  assign funct = ir[3:0];

  logic [DATA_WIDTH-1:0] rd_a, rd_b, alu_res;
  logic                  alu_ok;

  // Second read port carries the store source for STORE, source B otherwise.
  assign rd_a = regs[x2];
  assign rd_b = (op == 2'b11) ? regs[x1] : regs[x3];

  assign out = regs;

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (funct)
      4'h0:    alu_res = opa + opb;
      4'h1:    alu_res = opa - opb;
      4'h2:    alu_res = opa & opb;
      4'h3:    alu_res = opa | opb;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir    <= '0;
      opa   <= '0;
      opb   <= '0;
      addr  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= DATA_WIDTH'(i);
      for (int j = 0; j < MEM_WORDS; j++) mem[j] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= instruction;
          state <= DECODE;
        end
        DECODE: begin
          opa   <= rd_a;
          opb   <= rd_b;
          // Sum is formed at full word width; only the low address bits select the word.
          addr  <= ADDR_BITS'(rd_a + DATA_WIDTH'(imm));
          state <= EXECUTE;
        end
        EXECUTE: begin
          case (op)
            2'b01:   if (alu_ok) regs[x1] <= alu_res;
            2'b10:   regs[x1] <= mem[addr];
            2'b11:   mem[addr] <= opb;
            default: ;
          endcase
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// tb/tb_simple_cpu.sv - scoreboard bench for simple_cpu against a behavioural model
module tb_simple_cpu;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [19:0]       instruction = '0;
  logic [0:3][7:0]   out;

  simple_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .out         (out)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  int          m_reg [4];
  int          m_mem [32];

  function automatic logic [19:0] mk(int op, int x1, int x2, int x3, int imm, int f);
    logic [19:0] w;
    w = {2'(op), 2'(x1), 2'(x2), 2'(x3), 8'(imm), 4'(f)};
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = i;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
  endtask

  task automatic model_apply(input logic [19:0] ins);
    int op, x1, x2, x3, imm, f, a;
    op  = ins[19:18];
    x1  = ins[17:16];
    x2  = ins[15:14];
    x3  = ins[13:12];
    imm = ins[11:4];
    f   = ins[3:0];
    a   = (m_reg[x2] + imm) % 32;
    case (op)
      1: begin
        if (f == 0)      m_reg[x1] = (m_reg[x2] + m_reg[x3]) % 256;
        else if (f == 1) m_reg[x1] = (m_reg[x2] - m_reg[x3] + 256) % 256;
        else if (f == 2) m_reg[x1] = m_reg[x2] & m_reg[x3];
        else if (f == 3) m_reg[x1] = m_reg[x2] | m_reg[x3];
      end
      2: m_reg[x1] = m_mem[a];
      3: m_mem[a] = m_reg[x1];
      default: ;
    endcase
  endtask

  task automatic push_expect(input string tag);
    exp_q.push_back({8'(m_reg[0]), 8'(m_reg[1]), 8'(m_reg[2]), 8'(m_reg[3])});
    tag_q.push_back(tag);
  endtask

  // Called at a negedge whose following posedge is a FETCH; returns at a negedge.
  task automatic exec(input logic [19:0] ins, input string tag);
    instruction = ins;
    model_apply(ins);
    repeat (3) @(posedge clk);
    #1 push_expect(tag);
    @(negedge clk);
  endtask

  task automatic exec_change(input logic [19:0] ins, input logic [19:0] other, input string tag);
    instruction = ins;
    model_apply(ins);
    @(posedge clk);
    @(negedge clk);
    instruction = other;
    repeat (2) @(posedge clk);
    #1 push_expect(tag);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      compared++;
      if (out !== e) begin
        mismatched++;
        $display("FAIL %s: out got %h want %h", t, out, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 push_expect("reset_out");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    exec(20'h00000, "nop_after_reset");
    exec(20'h47000, "add_r0");
    exec(20'h53000, "add_r1");
    exec(20'h72001, "sub_r3");
    exec(20'hD80F0, "store_17");
    exec(20'hCC160, "store_24");
    exec(20'hB80F0, "load_17");

    // Reset asserted while an ADD sits in DECODE must abort it.
    instruction = mk(1, 0, 1, 3, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 push_expect("rst_in_decode");
    @(negedge clk);
    rst = 1'b0;
    exec(20'h00000, "nop_after_abort");
    exec(mk(2, 1, 0, 0, 17, 0), "load_cleared_mem");
    exec(mk(1, 2, 3, 0, 0, 5), "invalid_funct");

    exec(mk(1, 0, 0, 3, 0, 1), "sub_wrap_253");
    exec(mk(1, 1, 0, 0, 0, 0), "add_wrap_250");
    exec(mk(3, 1, 0, 0, 10, 0), "store_addr_wrap_7");
    exec(mk(2, 3, 2, 0, 5, 0), "load_addr_7");
    exec_change(mk(1, 2, 1, 1, 0, 0), mk(1, 0, 0, 0, 0, 3), "instr_change_in_decode");

    for (int n = 0; n < 60; n++) begin
      int f;
      f = ($urandom_range(0, 4) == 4) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      exec(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 255), f), $sformatf("random_%0d", n));
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
